// File: rtl/shift_add_mult8.sv
// rtl/shift_add_mult8.sv - sequential radix-2 shift-and-add unsigned multiplier
module shift_add_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mq_q;
  logic [WIDTH-1:0] m_q;
  logic [CW-1:0]    count_q;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0] q_shift;
  logic             last_iter;

  // One add stage per cycle; the carry becomes the new MSB of A after the shift.
  assign addend    = mq_q[0] ? m_q : '0;
  assign {carry, sum} = {1'b0, acc_q} + {1'b0, addend};
  assign acc_shift = {carry, sum[WIDTH-1:1]};
  assign q_shift   = {sum[0], mq_q[WIDTH-1:1]};
  assign last_iter = (count_q == CW'(WIDTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mq_q    <= '0;
      m_q     <= '0;
      count_q <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_q   <= '0;
            mq_q    <= b;
            m_q     <= a;
            count_q <= '0;
          end
        end
        RUN: begin
          acc_q   <= acc_shift;
          mq_q    <= q_shift;
          count_q <= count_q + 1'b1;
          // Product is taken from this iteration's shift so it is never partial.
          if (last_iter) product <= {acc_shift, q_shift};
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
